// File: rtl/gmii_tx_pkg.sv
// gmii_tx_pkg -- shared definitions for the Z80-attached GMII transmitter.
//
// Holds the transmit FSM state encoding, the I/O port offsets within the
// 4-byte decoded window, the control register bit positions, the framing
// constants, and a helper that packs the status byte.
package gmii_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SFD  = 3'd2,
    ST_DATA = 3'd3,
    ST_GAP  = 3'd4
  } tx_state_t;

  // Offsets within the decoded window (addr[1:0]).
  localparam logic [1:0] OFS_DATA   = 2'd0;  // write: push byte into FIFO
  localparam logic [1:0] OFS_CTRL   = 2'd1;  // write: bit0 start, bit1 clear
  localparam logic [1:0] OFS_STATUS = 2'd2;  // read : busy/full/overflow/count
  localparam logic [1:0] OFS_FRAMES = 2'd3;  // read : frames-sent counter

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_CLEAR_BIT = 1;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int unsigned PREAMBLE_LEN  = 7;

  // Status byte layout: {busy, full, overflow, count[4:0]}.
  function automatic logic [7:0] pack_status(input logic       busy,
                                             input logic       full,
                                             input logic       overflow,
                                             input logic [4:0] count);
    return {busy, full, overflow, count};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock show-ahead FIFO holding the bytes of the frame
// being assembled or transmitted.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   clear           synchronous flush (pointers and count to zero)
//   push, din       write request and data; ignored when full unless a pop
//                   frees a slot in the same cycle
//   pop             advance read pointer; ignored when empty
//   dout            head-of-queue byte, valid whenever empty is low
//   count           occupancy, 0..DEPTH
//   full, empty     occupancy flags
//
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A simultaneous pop frees the slot, so a push into a full FIFO is only
  // refused when nothing leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // NOTE: storage is deliberately left out of reset; only the pointers and
  // count define what is valid, and a resettable array costs a reset tree
  // for every bit with no functional benefit.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= din;
    end
  end

  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gmii_tx_io.sv
// gmii_tx_io -- Z80 I/O-mapped GMII frame transmitter.
//
// The CPU pushes frame bytes into a FIFO through the data port and launches
// transmission through the control port. The FSM sends 7 preamble bytes,
// the SFD, then drains the FIFO one byte per clock until it runs dry,
// followed by an IFG-cycle inter-frame gap.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   iorq_n, rd_n, wr_n    Z80 bus strobes (active low)
//   addr, wr_data         I/O address and CPU write data
//   rd_data, doe          CPU read data (0 when doe low) and its enable
//   tx_data, tx_dv, tx_er GMII transmit side; tx_er is tied low
//
// Port map relative to BASE: +0 data, +1 control, +2 status, +3 frames sent.
module gmii_tx_io
  import gmii_tx_pkg::*;
#(
  parameter logic [7:0]  BASE  = 8'h10,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IFG   = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       doe,
  output logic [7:0] tx_data,
  output logic       tx_dv,
  output logic       tx_er
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  // Bus decode
  logic       sel;
  logic [1:0] offset;
  logic       wr_act;
  logic       wr_q;
  logic       wr_edge;
  logic       data_wr;
  logic       ctrl_wr;
  logic       start_req;
  logic       clear_req;

  // FIFO interface
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;

  // Transmit state
  tx_state_t  state;
  logic [7:0] step_cnt;   // preamble / gap cycle counter (IFG <= 256)
  logic       overflow;
  logic [7:0] frames;
  logic [7:0] status;

  assign sel    = (addr[7:2] == BASE[7:2]);
  assign offset = addr[1:0];

  // A Z80 write strobe spans several clocks; act only on its first sampled
  // cycle so a held strobe performs exactly one access.
  assign wr_act  = !iorq_n && !wr_n && sel;
  assign wr_edge = wr_act && !wr_q;
  assign data_wr = wr_edge && (offset == OFS_DATA);
  assign ctrl_wr = wr_edge && (offset == OFS_CTRL);

  // Clear and start are both IDLE-only; clear takes priority when both
  // bits are written together.
  assign clear_req = ctrl_wr && wr_data[CTRL_CLEAR_BIT] && (state == ST_IDLE);
  assign start_req = ctrl_wr && wr_data[CTRL_START_BIT] && !wr_data[CTRL_CLEAR_BIT]
                     && (state == ST_IDLE) && !fifo_empty;

  // The edge that leaves SFD loads the first payload byte; each DATA edge
  // loads the next one while any remain.
  assign fifo_pop = (state == ST_SFD) || ((state == ST_DATA) && !fifo_empty);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear_req),
    .push  (data_wr),
    .pop   (fifo_pop),
    .din   (wr_data),
    .dout  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= 1'b0;
    end else begin
      wr_q <= wr_act;
    end
  end

  // Sticky overflow: a byte is lost only when full with no pop to make room.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (clear_req) begin
      overflow <= 1'b0;
    end else if (data_wr && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end
  end

  // Transmit FSM. tx_dv/tx_data are registered alongside the state, so the
  // state names the byte currently on the wire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      step_cnt <= '0;
      tx_dv    <= 1'b0;
      tx_data  <= 8'h00;
      frames   <= 8'h00;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start_req) begin
            state    <= ST_PRE;
            step_cnt <= '0;
            tx_dv    <= 1'b1;
            tx_data  <= PREAMBLE_BYTE;
          end
        end
        ST_PRE: begin
          if (step_cnt == 8'(PREAMBLE_LEN - 1)) begin
            state   <= ST_SFD;
            tx_data <= SFD_BYTE;
          end else begin
            step_cnt <= step_cnt + 8'd1;
          end
        end
        ST_SFD: begin
          state   <= ST_DATA;
          tx_data <= fifo_head;
        end
        ST_DATA: begin
          if (!fifo_empty) begin
            tx_data <= fifo_head;
          end else begin
            state    <= ST_GAP;
            step_cnt <= '0;
            tx_dv    <= 1'b0;
            tx_data  <= 8'h00;
            frames   <= frames + 8'd1;
          end
        end
        ST_GAP: begin
          if (step_cnt == 8'(IFG - 1)) begin
            state <= ST_IDLE;
          end else begin
            step_cnt <= step_cnt + 8'd1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          tx_dv   <= 1'b0;
          tx_data <= 8'h00;
        end
      endcase
    end
  end

  assign status = pack_status(state != ST_IDLE, fifo_full, overflow, 5'(fifo_count));

  assign doe   = !iorq_n && !rd_n && sel && offset[1];
  assign tx_er = 1'b0;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_data = 8'h00;
    if (doe) begin
      rd_data = (offset == OFS_STATUS) ? status : frames;
    end
  end

endmodule

// File: tb/tb_gmii_tx_io.sv
// tb_gmii_tx_io -- directed self-checking bench for gmii_tx_io
// (BASE=8'h10, DEPTH=16, IFG=12). Inputs change on the falling edge and
// outputs are sampled on or shortly after it.
module tb_gmii_tx_io;

  localparam logic [7:0] A_DATA = 8'h10;
  localparam logic [7:0] A_CTRL = 8'h11;
  localparam logic [7:0] A_STAT = 8'h12;
  localparam logic [7:0] A_FRMS = 8'h13;

  logic       clk = 1'b0;
  logic       reset;
  logic       iorq_n;
  logic       rd_n;
  logic       wr_n;
  logic [7:0] addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       doe;
  logic [7:0] tx_data;
  logic       tx_dv;
  logic       tx_er;

  int n_cmp  = 0;
  int n_fail = 0;

  // Transmit-side monitor results
  logic [7:0] cap_q[$];
  logic [7:0] exp_q[$];
  int         dv_run   = 0;
  int         last_run = 0;
  int         idle_bad = 0;

  gmii_tx_io #(
    .BASE  (8'h10),
    .DEPTH (16),
    .IFG   (12)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .iorq_n  (iorq_n),
    .rd_n    (rd_n),
    .wr_n    (wr_n),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .doe     (doe),
    .tx_data (tx_data),
    .tx_dv   (tx_dv),
    .tx_er   (tx_er)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_dv) begin
      cap_q.push_back(tx_data);
      dv_run <= dv_run + 1;
    end else begin
      if (dv_run != 0) last_run <= dv_run;
      dv_run <= 0;
      if (tx_data !== 8'h00 || tx_er !== 1'b0) idle_bad <= idle_bad + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  // All bus tasks start just after a falling edge and return on one.
  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    addr = a; wr_data = d; iorq_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    iorq_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic io_read(input logic [7:0] a, output logic [7:0] d, output logic o);
    addr = a; iorq_n = 1'b0; rd_n = 1'b0;
    #2;
    d = rd_data;
    o = doe;
    iorq_n = 1'b1; rd_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_frame_end(input int budget, output bit ok);
    bit seen = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (tx_dv) seen = 1'b1;
      else if (seen) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Reads status each cycle from the first gap cycle until busy clears.
  task automatic count_busy(output int n);
    logic [7:0] d;
    logic       o;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      io_read(A_STAT, d, o);
      if (d[7]) n++;
      else break;
    end
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] payload[$]);
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (payload[i]) exp_q.push_back(payload[i]);
    check({tag, "_len"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), (i < cap_q.size()) ? cap_q[i] : 8'hxx, exp_q[i]);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       o;
    bit         ok;
    int         busy_n;
    logic [7:0] pl[$];

    reset = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    addr = 8'h00; wr_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx_dv", tx_dv, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_er", tx_er, 1'b0);
    check("idle_doe", doe, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    io_read(A_STAT, d, o);
    check("rst_status", d, 8'h00);
    check("rd_doe", o, 1'b1);
    check("doe_released", doe, 1'b0);
    io_read(A_FRMS, d, o);
    check("rst_frames", d, 8'h00);
    io_read(8'h22, d, o);
    check("unsel_doe", o, 1'b0);
    check("unsel_rd_data", d, 8'h00);
    io_read(A_DATA, d, o);
    check("dataport_rd_doe", o, 1'b0);

    // Three-byte frame
    io_write(A_DATA, 8'h11);
    io_write(A_DATA, 8'h22);
    io_write(A_DATA, 8'h33);
    io_read(A_STAT, d, o);
    check("s1_status_pre", d, 8'h03);
    cap_q.delete();
    io_write(A_CTRL, 8'h01);
    wait_frame_end(100, ok);
    check("s1_frame_done", ok, 1'b1);
    count_busy(busy_n);
    check("s1_gap_cycles", busy_n, 12);
    check("s1_dv_run", last_run, 11);
    pl = '{8'h11, 8'h22, 8'h33};
    expect_frame("s1", pl);
    io_read(A_FRMS, d, o);
    check("s1_frames", d, 8'h01);
    io_read(A_STAT, d, o);
    check("s1_status_post", d, 8'h00);

    // One strobe held for four cycles pushes once
    addr = A_DATA; wr_data = 8'hA5; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (4) @(negedge clk);
    iorq_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
    io_read(A_STAT, d, o);
    check("held_strobe_count", d, 8'h01);
    io_write(A_CTRL, 8'h02);

    // Fill, overflow, clear
    for (int i = 0; i < 17; i++) begin
      io_write(A_DATA, 8'(i));
      if (i == 15) begin
        io_read(A_STAT, d, o);
        check("full_status", d, 8'h50);
      end
    end
    io_read(A_STAT, d, o);
    check("overflow_status", d, 8'h70);
    io_write(A_CTRL, 8'h02);
    io_read(A_STAT, d, o);
    check("cleared_status", d, 8'h00);

    // Start and clear together: clear wins
    io_write(A_DATA, 8'hE1);
    io_write(A_DATA, 8'hE2);
    io_write(A_CTRL, 8'h03);
    io_read(A_STAT, d, o);
    check("start_clear_status", d, 8'h00);
    check("start_clear_tx_dv", tx_dv, 1'b0);

    // Start with empty FIFO is ignored
    io_write(A_CTRL, 8'h01);
    repeat (2) @(negedge clk);
    check("empty_start_tx_dv", tx_dv, 1'b0);
    io_read(A_STAT, d, o);
    check("empty_start_status", d, 8'h00);

    // Streaming: bytes appended while the frame runs; clear is ignored
    for (int i = 0; i < 8; i++) io_write(A_DATA, 8'h40 + 8'(i));
    cap_q.delete();
    io_write(A_CTRL, 8'h01);
    for (int i = 8; i < 12; i++) io_write(A_DATA, 8'h40 + 8'(i));
    io_write(A_CTRL, 8'h02);
    io_read(A_STAT, d, o);
    check("stream_status", d, 8'h88);
    wait_frame_end(100, ok);
    check("stream_frame_done", ok, 1'b1);
    count_busy(busy_n);
    check("stream_dv_run", last_run, 20);
    pl.delete();
    for (int i = 0; i < 12; i++) pl.push_back(8'h40 + 8'(i));
    expect_frame("stream", pl);
    io_read(A_FRMS, d, o);
    check("stream_frames", d, 8'h02);

    // Reset in the middle of DATA
    for (int i = 0; i < 5; i++) io_write(A_DATA, 8'hC0 + 8'(i));
    io_write(A_CTRL, 8'h01);
    repeat (10) @(negedge clk);
    check("mid_frame_tx_dv", tx_dv, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_tx_dv", tx_dv, 1'b0);
    check("async_rst_tx_data", tx_data, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    io_read(A_STAT, d, o);
    check("post_rst_status", d, 8'h00);
    io_read(A_FRMS, d, o);
    check("post_rst_frames", d, 8'h00);

    // First access after reset is accepted
    io_write(A_DATA, 8'h99);
    cap_q.delete();
    io_write(A_CTRL, 8'h01);
    wait_frame_end(100, ok);
    check("post_rst_frame_done", ok, 1'b1);
    count_busy(busy_n);
    check("post_rst_dv_run", last_run, 9);
    pl = '{8'h99};
    expect_frame("post_rst", pl);
    io_read(A_FRMS, d, o);
    check("post_rst_frames_1", d, 8'h01);

    check("idle_bus_quiet", idle_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gmii_tx_io.md
GMII_TX_IO -- requirements
Module: gmii_tx_io

Interface
REQ-001 Parameter BASE, default 8'h10, SHALL set the I/O base address; the block decodes addr[7:2] == BASE[7:2].
REQ-002 Parameter DEPTH, default 16, SHALL set the transmit FIFO depth in bytes (power of two).
REQ-003 Parameter IFG, default 12, SHALL set the inter-frame gap in clk cycles.
REQ-004 Port list:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- iorq_n  in  1  Z80 I/O request.
- rd_n  in  1  Z80 read strobe.
- wr_n  in  1  Z80 write strobe.
- addr  in  8  I/O port address.
- wr_data  in  8  CPU write data.
- rd_data  out  8  CPU read data.
- doe  out  1  rd_data valid; drives the shared di bus.
- tx_data  out  8  GMII transmit byte.
- tx_dv  out  1  GMII transmit data valid.
- tx_er  out  1  GMII transmit error; tied 0.

Function
REQ-005 Port offsets SHALL be: 0 data write (push to FIFO); 1 control write (bit0 start, bit1 clear); 2 status read; 3 frames-sent count read.
REQ-006 A write access SHALL act exactly once: on the first rising edge where !iorq_n & !wr_n & select is sampled high after being low.
REQ-007 doe SHALL equal !iorq_n & !rd_n & select & (offset 2 or 3), combinationally; rd_data SHALL be 0 when doe is low.
REQ-008 Status SHALL read as: bit7 busy (state != IDLE), bit6 full, bit5 overflow (sticky), bits4:0 FIFO count (0..DEPTH).
REQ-009 A data write with the FIFO full SHALL drop the byte and set overflow; the count SHALL be unchanged.
REQ-010 Data writes SHALL be accepted in any state, so the FIFO can stream during DATA.
REQ-011 Clear SHALL flush the FIFO and clear overflow only in IDLE; in any other state it SHALL be ignored.
REQ-012 Start SHALL be ignored unless state is IDLE and count > 0.
REQ-013 If start and clear are written together in IDLE, clear SHALL win and no frame SHALL start.
REQ-014 FSM states and transitions:
- IDLE: -> PRE on an accepted start (edge E).
- PRE: 7 cycles, tx_data=8'h55.
- SFD: 1 cycle, tx_data=8'hD5.
- DATA: one FIFO byte per cycle; leaves after the cycle that pops the last byte.
- GAP: IFG cycles with tx_dv=0, then -> IDLE.
REQ-015 tx_dv and tx_data SHALL be registered; tx_dv SHALL be high from the cycle after E through the last DATA byte.
REQ-016 A frame of N bytes SHALL produce exactly 8+N consecutive tx_dv-high cycles.
REQ-017 If the FIFO empties during DATA, the frame SHALL end at that byte; the block SHALL never underrun or insert idle bytes.
REQ-018 A push and a pop in the same cycle SHALL leave the count unchanged and lose no data.
REQ-019 The frames-sent count SHALL increment on DATA->GAP, wrapping at 8 bits (255 -> 0).
REQ-020 tx_data SHALL be 8'h00 whenever tx_dv is 0.

Reset
REQ-021 On reset assertion, asynchronously and including mid-frame, the block SHALL enter IDLE with tx_dv=0, tx_data=0, FIFO empty, overflow=0, frames-sent=0 and the write-edge history cleared.
REQ-022 After reset deasserts, the block SHALL accept the first CPU access on the next qualifying edge.

Structure
REQ-023 A shared package gmii_tx_pkg SHALL hold the state encoding, the port offsets, PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5 and PREAMBLE_LEN=7.
REQ-024 A sub-module sync_fifo (DEPTH x 8, with count, full and empty outputs) SHALL hold the buffer; gmii_tx_io SHALL contain the decode, strobe-edge detection and FSM.

Verification
REQ-025 The bench SHALL cover these scenarios:
- Write 0x11, 0x22, 0x33, then start -> 7x55, D5, 11, 22, 33 with tx_dv high for 11 cycles, then 12 idle cycles; frames-sent = 1.
- Hold a single OUT strobe for 4 cycles -> exactly one FIFO push; status count = 1.
- Write 17 bytes -> status = 0x50 (full, count 16) plus overflow, i.e. 0x70; clear -> status = 0x20 cleared to 0x00.
- Start with an empty FIFO -> tx_dv stays 0 and status busy = 0.
- During DATA, write extra bytes faster than the pop rate -> all bytes are sent in order in one frame.
- Assert reset during DATA -> tx_dv = 0 immediately, status = 0x00, frames-sent = 0.
